// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target: controller states and synchronizer depth.
package spi_target_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-bit flop-chain synchronizer (SYNC_STAGES deep) with a per-bit reset value.
module spi_sync
  import spi_target_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= {SYNC_STAGES{RST_VAL}};
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, oversampled on i_clk. Define SPI_TARGET_MISO_EN to build the
// MISO transmit path; otherwise o_miso and o_tx_req are tied low.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int WORD = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_sck,
  input  logic            i_mosi,
  input  logic            i_cs_n,
  output logic            o_miso,
  output logic [WORD-1:0] o_data,
  output logic            o_valid,
  output logic            o_first,
  output logic            o_abort,
  output logic            o_tx_req,
  input  logic [WORD-1:0] i_tx_data
);

  localparam int              CNT_W = $clog2(WORD);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORD - 1);

  state_t state, state_n;

  logic [2:0]       pins_s;
  logic             cs_s, sck_s, mosi_s;
  logic             cs_q, sck_q;
  logic             cs_fall, cs_rise, sck_rise, sck_fall;
  logic [1:0]       settle_cnt;
  logic             armed;
  logic [CNT_W-1:0] bit_cnt;
  logic [WORD-1:0]  rx_shift;
  logic             first_pending;
  logic             take_bit, word_done, abort_n;

  // CS resets high and SCK low so a reset never fabricates an edge.
  spi_sync #(
    .WIDTH   (3),
    .RST_VAL (3'b100)
  ) u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   ({i_cs_n, i_sck, i_mosi}),
    .q   (pins_s)
  );

  assign cs_s   = pins_s[2];
  assign sck_s  = pins_s[1];
  assign mosi_s = pins_s[0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cs_q  <= 1'b1;
      sck_q <= 1'b0;
    end else begin
      cs_q  <= cs_s;
      sck_q <= sck_s;
    end
  end

  assign cs_fall  = cs_q & ~cs_s;
  assign cs_rise  = ~cs_q & cs_s;
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;

  // After reset the chain must flush before CS is trusted; a transaction that was
  // open across reset then needs CS to go high and fall again before it restarts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      if (settle_cnt != 2'(SYNC_STAGES)) settle_cnt <= settle_cnt + 2'd1;
      if (settle_cnt == 2'(SYNC_STAGES) && cs_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (cs_fall && armed) state_n = LOAD;
      LOAD:    state_n = cs_s ? IDLE : SHIFT;
      SHIFT:   if (cs_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // SCK edges count only in SHIFT; the CS-release cycle still accepts a final bit.
  assign take_bit  = (state == SHIFT) && sck_rise;
  assign word_done = take_bit && (bit_cnt == LAST);
  assign abort_n   = (state == SHIFT) && cs_rise && !word_done
                     && ((bit_cnt != '0) || take_bit);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bit_cnt       <= '0;
      rx_shift      <= '0;
      first_pending <= 1'b0;
      o_data        <= '0;
      o_valid       <= 1'b0;
      o_first       <= 1'b0;
      o_abort       <= 1'b0;
    end else begin
      o_valid <= word_done;
      o_first <= word_done && first_pending;
      o_abort <= abort_n;

      if (word_done) o_data <= {rx_shift[WORD-2:0], mosi_s};

      if (state == LOAD)  first_pending <= 1'b1;
      else if (word_done) first_pending <= 1'b0;

      if (state != SHIFT || cs_rise) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (take_bit) begin
        rx_shift <= {rx_shift[WORD-2:0], mosi_s};
        bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
      end
    end
  end

`ifdef SPI_TARGET_MISO_EN
  logic [WORD-1:0] tx_shift;

  assign o_tx_req = (state == LOAD) || (o_valid && state == SHIFT);

  // The falling edge that closes a word does not shift: the reload already put the
  // next word's MSB on the line, and the bit counter is back at zero there.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_shift <= '0;
    end else if (state == IDLE) begin
      tx_shift <= '0;
    end else if (o_tx_req) begin
      tx_shift <= i_tx_data;
    end else if (state == SHIFT && sck_fall && bit_cnt != '0) begin
      tx_shift <= {tx_shift[WORD-2:0], 1'b0};
    end
  end

  assign o_miso = (state != IDLE) && tx_shift[WORD-1];
`else
  logic unused_tx;

  assign unused_tx = ^{i_tx_data, sck_fall};
  assign o_tx_req  = 1'b0;
  assign o_miso    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: host-side SPI driver, receive-word scoreboard, pulse counters.
`timescale 1ns/1ps
module tb_spi_target;

  localparam int HALF = 60;

  logic       clk, rst, sck, mosi, cs_n, miso;
  logic [7:0] data, tx_data;
  logic       valid, first, abort, tx_req;

  int errors = 0;
  int checks = 0;
  int n_valid = 0, n_abort = 0, n_tx_req = 0, n_miso_high = 0, n_idle_miso = 0;
  bit watch_idle = 1'b0;

  logic [8:0] sb_q[$];

  spi_target #(.WORD(8)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_sck     (sck),
    .i_mosi    (mosi),
    .i_cs_n    (cs_n),
    .o_miso    (miso),
    .o_data    (data),
    .o_valid   (valid),
    .o_first   (first),
    .o_abort   (abort),
    .o_tx_req  (tx_req),
    .i_tx_data (tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor on the falling clock edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        check("unexpected_valid", {first, data}, 64'h1ff);
      end else begin
        check("rx_word", {first, data}, sb_q.pop_front());
      end
    end
    if (abort)  n_abort++;
    if (tx_req) n_tx_req++;
    if (miso)   n_miso_high++;
    if (miso && watch_idle) n_idle_miso++;
  end

  // Host side of mode 0: drive MOSI while SCK low, sample MISO at each rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      #HALF;
      sck = 1'b1;
      rx = {rx[6:0], miso};
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},   data,   0);
    check({tag, "_valid"},  valid,  0);
    check({tag, "_first"},  first,  0);
    check({tag, "_abort"},  abort,  0);
    check({tag, "_tx_req"}, tx_req, 0);
    check({tag, "_miso"},   miso,   0);
  endtask

  int         v0, a0, t0;
  logic [7:0] rx0, rx1, rx_dummy;

  initial begin
    rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Two-word transaction: command 0x2C then 0xA5; MISO returns 0x5A then 0xC3.
    v0 = n_valid; a0 = n_abort; t0 = n_tx_req;
    tx_data = 8'h5A;
    sb_q.push_back({1'b1, 8'h2C});
    sb_q.push_back({1'b0, 8'hA5});
    cs_n = 1'b0;
    #80 tx_data = 8'hC3;
    #20;
    spi_bits(8'h2C, 8, rx0);
    spi_bits(8'hA5, 8, rx1);
    #HALF cs_n = 1'b1;
    #200;
    check("two_words_valid_count", n_valid - v0, 2);
    check("two_words_no_abort", n_abort - a0, 0);
    check("two_words_data", data, 8'hA5);
`ifdef SPI_TARGET_MISO_EN
    check("miso_word0", rx0, 8'h5A);
    check("miso_word1", rx1, 8'hC3);
    check("tx_req_count", n_tx_req - t0, 3);
`else
    check("miso_word0_off", rx0, 8'h00);
    check("miso_word1_off", rx1, 8'h00);
    check("tx_req_count_off", n_tx_req - t0, 0);
`endif
    check("idle_miso", miso, 0);

    // CS released after 5 bits: one abort, no valid, o_data unchanged.
    v0 = n_valid; a0 = n_abort;
    cs_n = 1'b0;
    #100;
    spi_bits(8'hFF, 5, rx_dummy);
    #HALF cs_n = 1'b1;
    #200;
    check("abort_count", n_abort - a0, 1);
    check("abort_no_valid", n_valid - v0, 0);
    check("abort_data_kept", data, 8'hA5);

    // SCK toggling with CS high is ignored.
    v0 = n_valid; t0 = n_tx_req;
    watch_idle = 1'b1;
    mosi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #HALF sck = 1'b1;
      #HALF sck = 1'b0;
    end
    #100;
    watch_idle = 1'b0;
    check("cs_high_no_valid", n_valid - v0, 0);
    check("cs_high_no_tx_req", n_tx_req - t0, 0);
    check("cs_high_miso", n_idle_miso, 0);

    // Reset after 3 bits: everything clears silently, next transaction starts fresh.
    a0 = n_abort;
    cs_n = 1'b0;
    #100;
    spi_bits(8'hE0, 3, rx_dummy);
    rst = 1'b1;
    #30 cs_n = 1'b1;
    #30;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    #200;
    check("reset_no_abort", n_abort - a0, 0);
    v0 = n_valid;
    sb_q.push_back({1'b1, 8'h11});
    cs_n = 1'b0;
    #100;
    spi_bits(8'h11, 8, rx_dummy);
    #HALF cs_n = 1'b1;
    #200;
    check("after_reset_valid", n_valid - v0, 1);
    check("after_reset_data", data, 8'h11);

    // CS release coincident with the last SCK rising edge still completes the word.
    v0 = n_valid; a0 = n_abort;
    sb_q.push_back({1'b1, 8'h96});
    cs_n = 1'b0;
    #100;
    spi_bits(8'h96, 7, rx_dummy);
    mosi = 1'b0;
    #HALF;
    sck = 1'b1;
    cs_n = 1'b1;
    #HALF sck = 1'b0;
    #200;
    check("coincident_valid", n_valid - v0, 1);
    check("coincident_no_abort", n_abort - a0, 0);
    check("coincident_data", data, 8'h96);

    // Single command word 0x36.
    v0 = n_valid; t0 = n_tx_req;
    tx_data = 8'h81;
    sb_q.push_back({1'b1, 8'h36});
    cs_n = 1'b0;
    #100;
    spi_bits(8'h36, 8, rx0);
    #HALF cs_n = 1'b1;
    #200;
    check("word36_valid", n_valid - v0, 1);
    check("word36_data", data, 8'h36);
`ifdef SPI_TARGET_MISO_EN
    check("word36_miso", rx0, 8'h81);
`else
    check("word36_tx_req_off", n_tx_req, 0);
    check("miso_never_high_off", n_miso_high, 0);
`endif

    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
